// File: rtl/cache_pkg.sv
// Shared types and default sizing for the N-way set-associative LRU cache.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WTHRU = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 11;
  localparam int DEF_NUM_WAYS   = 4;
  localparam int DEF_NUM_SETS   = 16;
  localparam int DEF_CNT_WIDTH  = 16;

  localparam int DEF_IDX_W = $clog2(DEF_NUM_SETS);
  localparam int DEF_WAY_W = $clog2(DEF_NUM_WAYS);
  localparam int DEF_TAG_W = DEF_ADDR_WIDTH - DEF_IDX_W;

endpackage

// File: rtl/cache_lru_tracker.sv
// Per-set true-LRU age tracking: update on hit/fill and victim selection.
module cache_lru_tracker
  import cache_pkg::*;
#(
  parameter  int NUM_WAYS = DEF_NUM_WAYS,
  parameter  int NUM_SETS = DEF_NUM_SETS,
  localparam int WAY_W    = $clog2(NUM_WAYS),
  localparam int IDX_W    = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upd_en,
  input  logic [IDX_W-1:0]    upd_idx,
  input  logic [WAY_W-1:0]    upd_way,
  input  logic [IDX_W-1:0]    vic_idx,
  input  logic [NUM_WAYS-1:0] vic_valid,
  output logic [WAY_W-1:0]    vic_way
);

  // Age 0 is most recently used, NUM_WAYS-1 is the eviction candidate.
  logic [WAY_W-1:0] ages_q [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0] upd_age;

  assign upd_age = ages_q[upd_idx][upd_way];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          ages_q[s][w] <= WAY_W'(w);
        end
      end
    end else if (upd_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == upd_way) begin
          ages_q[upd_idx][w] <= '0;
        end else if (ages_q[upd_idx][w] < upd_age) begin
          ages_q[upd_idx][w] <= ages_q[upd_idx][w] + WAY_W'(1);
        end
      end
    end
  end

  // NOTE: always_comb outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    vic_way = '0;
    if (&vic_valid) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (ages_q[vic_idx][w] == WAY_W'(NUM_WAYS - 1)) vic_way = WAY_W'(w);
      end
    end else begin
      // Descending scan so the lowest-index invalid way is the last one written.
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
        if (!vic_valid[w]) vic_way = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/cache_nway_lru.sv
// N-way set-associative, write-through, read-allocate cache with true-LRU replacement.
module cache_nway_lru
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WAYS   = DEF_NUM_WAYS,
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;
  localparam int WAY_W = $clog2(NUM_WAYS);

  state_e state_q, state_d;

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic                  hit_q;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, miss_cnt_q;

  logic                  accept, fill, wr_hit;
  logic [IDX_W-1:0]      req_idx, fill_idx;
  logic [TAG_W-1:0]      req_tag, fill_tag;
  logic                  lk_hit;
  logic [WAY_W-1:0]      lk_way, vic_way;
  logic [DATA_WIDTH-1:0] lk_data;

  assign req_idx  = req_addr[IDX_W-1:0];
  assign req_tag  = req_addr[ADDR_WIDTH-1:IDX_W];
  assign fill_idx = addr_q[IDX_W-1:0];
  assign fill_tag = addr_q[ADDR_WIDTH-1:IDX_W];

  assign accept = req_valid & req_ready;
  assign fill   = (state_q == ST_FILL) & mem_ack;
  assign wr_hit = accept & req_write & lk_hit;

  always_comb begin
    lk_hit  = 1'b0;
    lk_way  = '0;
    lk_data = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        lk_hit  = 1'b1;
        lk_way  = WAY_W'(w);
        lk_data = data_q[req_idx][w];
      end
    end
  end

  // Hits update LRU at accept, fills on mem_ack; the two never coincide.
  cache_lru_tracker #(
    .NUM_WAYS (NUM_WAYS),
    .NUM_SETS (NUM_SETS)
  ) u_lru (
    .clk       (clk),
    .rst       (rst),
    .upd_en    ((accept & lk_hit) | fill),
    .upd_idx   (fill ? fill_idx : req_idx),
    .upd_way   (fill ? vic_way : lk_way),
    .vic_idx   (fill_idx),
    .vic_valid (valid_q[fill_idx]),
    .vic_way   (vic_way)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else if (fill) begin
      valid_q[fill_idx][vic_way] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays have no reset; valid_q alone decides whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (wr_hit) data_q[req_idx][lk_way] <= req_wdata;
    if (fill) begin
      tag_q[fill_idx][vic_way]  <= fill_tag;
      data_q[fill_idx][vic_way] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        hit_q   <= lk_hit;
        rdata_q <= req_write ? req_wdata : lk_data;
        if (lk_hit && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + CNT_WIDTH'(1);
        if (!lk_hit && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
      end
      if (fill) rdata_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_write)   state_d = ST_WTHRU;
          else if (lk_hit) state_d = ST_RESP;
          else             state_d = ST_FILL;
        end
      end
      ST_FILL, ST_WTHRU: if (mem_ack) state_d = ST_RESP;
      ST_RESP:           state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode the state register directly so an async reset drops them at once.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    mem_req    = (state_q == ST_FILL) || (state_q == ST_WTHRU);
    mem_we     = (state_q == ST_WTHRU);
  end

  assign resp_rdata = rdata_q;
  assign resp_hit   = hit_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_nway_lru.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random traffic vs. LRU model.
module tb_cache_nway_lru;

  localparam int AW = 11;
  localparam int DW = 11;
  localparam int NW = 4;
  localparam int NS = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_hit;
  logic [DW-1:0] resp_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] hit_count, miss_count;

  cache_nway_lru #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_WAYS (NW), .NUM_SETS (NS), .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_hit   (resp_hit),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Backing memory: written words are remembered, everything else follows a fixed pattern.
  logic [DW-1:0] mem_m [int];

  function automatic logic [DW-1:0] mem_val(input int a);
    if (mem_m.exists(a)) return mem_m[a];
    return DW'((a * 37 + 5) & 'h7FF);
  endfunction

  // Cache model: resident addresses with last-use timestamps; a full set evicts its oldest.
  int last_use [int];
  int now_t  = 0;
  int m_hits = 0;
  int m_miss = 0;

  function automatic bit model_access(input bit wr, input int a);
    int cnt      = 0;
    int oldest   = -1;
    int oldest_t = 0;
    bit hit      = last_use.exists(a);
    if (hit) begin
      last_use[a] = now_t;
    end else if (!wr) begin
      foreach (last_use[k]) begin
        if ((k % NS) == (a % NS)) begin
          cnt++;
          if (oldest < 0 || last_use[k] < oldest_t) begin
            oldest   = k;
            oldest_t = last_use[k];
          end
        end
      end
      if (cnt == NW) last_use.delete(oldest);
      last_use[a] = now_t;
    end
    now_t++;
    if (hit) m_hits++;
    else     m_miss++;
    return hit;
  endfunction

  // One complete request; acts as the memory responder when the cache goes to memory.
  task automatic do_req(input string nm, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input bit exp_hit, input logic [DW-1:0] exp_rd, input int delay);
    int guard = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check({nm, " ready"}, 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    if (!wr && exp_hit) begin
      check({nm, " hit resp_valid"}, 32'(resp_valid), 1);
      check({nm, " hit mem_req"},    32'(mem_req), 0);
      check({nm, " hit resp_hit"},   32'(resp_hit), 1);
      check({nm, " hit rdata"},      32'(resp_rdata), 32'(exp_rd));
    end else begin
      check({nm, " mem_req"},   32'(mem_req), 1);
      check({nm, " mem_we"},    32'(mem_we), 32'(wr));
      check({nm, " mem_addr"},  32'(mem_addr), 32'(a));
      if (wr) check({nm, " mem_wdata"}, 32'(mem_wdata), 32'(wd));
      check({nm, " early resp"}, 32'(resp_valid), 0);
      for (int i = 0; i < delay; i++) begin
        @(posedge clk); #1;
        check({nm, " held mem_req"},  32'(mem_req), 1);
        check({nm, " held mem_addr"}, 32'(mem_addr), 32'(a));
        check({nm, " busy ready"},    32'(req_ready), 0);
      end
      mem_ack   = 1'b1;
      mem_rdata = wr ? DW'($urandom) : mem_val(int'(a));
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = DW'($urandom);
      if (wr) mem_m[int'(a)] = wd;
      check({nm, " resp_valid"}, 32'(resp_valid), 1);
      check({nm, " mem_req off"}, 32'(mem_req), 0);
      check({nm, " resp_hit"},   32'(resp_hit), 32'(exp_hit));
      check({nm, " rdata"},      32'(resp_rdata), 32'(exp_rd));
    end
    @(posedge clk); #1;
    check({nm, " resp pulse"}, 32'(resp_valid), 0);
    check({nm, " idle ready"}, 32'(req_ready), 1);
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            exp_hit;
    logic [DW-1:0] exp_rd;
    int            delay;
  } vec_t;

  function automatic vec_t mk(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input bit h, input logic [DW-1:0] rd, input int d);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.exp_hit = h; v.exp_rd = rd; v.delay = d;
    return v;
  endfunction

  vec_t vt [$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            wr, h;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    mem_m[int'(11'h123)] = 11'h456;

    vt.push_back(mk(0, 11'h123, 11'h000, 0, 11'h456, 0));
    vt.push_back(mk(0, 11'h123, 11'h000, 1, 11'h456, 0));
    vt.push_back(mk(0, 11'h2A3, 11'h000, 0, mem_val('h2A3), 1));
    vt.push_back(mk(0, 11'h333, 11'h000, 0, mem_val('h333), 0));
    vt.push_back(mk(0, 11'h413, 11'h000, 0, mem_val('h413), 5));
    vt.push_back(mk(0, 11'h123, 11'h000, 1, 11'h456, 0));
    vt.push_back(mk(0, 11'h503, 11'h000, 0, mem_val('h503), 0));
    vt.push_back(mk(0, 11'h123, 11'h000, 1, 11'h456, 0));
    vt.push_back(mk(0, 11'h2A3, 11'h000, 0, mem_val('h2A3), 2));
    vt.push_back(mk(1, 11'h123, 11'h7FF, 1, 11'h7FF, 2));
    vt.push_back(mk(0, 11'h123, 11'h000, 1, 11'h7FF, 0));
    vt.push_back(mk(1, 11'h600, 11'h155, 0, 11'h155, 0));
    vt.push_back(mk(0, 11'h600, 11'h000, 0, 11'h155, 1));
    vt.push_back(mk(0, 11'h124, 11'h000, 0, mem_val('h124), 0));
    vt.push_back(mk(0, 11'h123, 11'h000, 1, 11'h7FF, 0));

    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready",  32'(req_ready), 1);
    check("reset resp_valid", 32'(resp_valid), 0);
    check("reset mem_req",    32'(mem_req), 0);
    check("reset mem_we",     32'(mem_we), 0);
    check("reset mem_addr",   32'(mem_addr), 0);
    check("reset rdata",      32'(resp_rdata), 0);
    check("reset hit_count",  32'(hit_count), 0);
    check("reset miss_count", 32'(miss_count), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      do_req($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata,
             vt[i].exp_hit, vt[i].exp_rd, vt[i].delay);
      if (i == 1) begin
        check("vec1 hit_count",  32'(hit_count), 1);
        check("vec1 miss_count", 32'(miss_count), 1);
      end
    end
    check("table hit_count",  32'(hit_count), 6);
    check("table miss_count", 32'(miss_count), 9);

    // A stray ack while idle must not produce a response.
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("stray ack resp_valid", 32'(resp_valid), 0);
    check("stray ack ready",      32'(req_ready), 1);

    // Second request held valid during a miss is accepted only after the response.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 11'h7A5;
    @(posedge clk); #1;
    req_addr = 11'h123;
    check("b2b mem_req", 32'(mem_req), 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("b2b busy ready", 32'(req_ready), 0);
      check("b2b busy resp",  32'(resp_valid), 0);
    end
    mem_ack = 1'b1; mem_rdata = mem_val('h7A5);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("b2b first resp",  32'(resp_valid), 1);
    check("b2b first rdata", 32'(resp_rdata), 32'(mem_val('h7A5)));
    check("b2b resp ready",  32'(req_ready), 0);
    @(posedge clk); #1;
    check("b2b idle ready",  32'(req_ready), 1);
    check("b2b hits before", 32'(hit_count), 6);
    check("b2b miss before", 32'(miss_count), 10);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b second resp",  32'(resp_valid), 1);
    check("b2b second hit",   32'(resp_hit), 1);
    check("b2b second rdata", 32'(resp_rdata), 32'h7FF);
    check("b2b hits after",   32'(hit_count), 7);
    @(posedge clk); #1;

    // Reset asserted during a fill abandons the transaction immediately.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 11'h3C1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstfill mem_req before", 32'(mem_req), 1);
    rst = 1'b1;
    #1;
    check("rstfill mem_req",    32'(mem_req), 0);
    check("rstfill resp_valid", 32'(resp_valid), 0);
    check("rstfill ready",      32'(req_ready), 1);
    check("rstfill hit_count",  32'(hit_count), 0);
    check("rstfill miss_count", 32'(miss_count), 0);
    check("rstfill mem_addr",   32'(mem_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_use.delete();
    m_hits = 0;
    m_miss = 0;
    @(posedge clk); #1;

    h = model_access(1'b0, 'h123);
    do_req("post-rst", 1'b0, 11'h123, 11'h000, h, mem_val('h123), 0);
    check("post-rst missed", 32'(h), 0);

    // Random traffic over three sets, six tags each, so sets overflow and evict.
    for (int n = 0; n < 300; n++) begin
      wr = ($urandom_range(0, 99) < 30);
      a  = AW'(($urandom_range(0, 5) << 4) | $urandom_range(0, 2));
      wd = DW'($urandom);
      h  = model_access(wr, int'(a));
      rd = wr ? wd : mem_val(int'(a));
      do_req("rand", wr, a, wd, h, rd, int'($urandom_range(0, 3)));
    end
    check("rand hit_count",  32'(hit_count), 32'(m_hits));
    check("rand miss_count", 32'(miss_count), 32'(m_miss));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
